serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl_pkg.sv | 22 ++
 rtl/serial_add_ctrl_fa.sv | 11 +
 rtl/serial_add_ctrl.sv | 97 +++++++++
 tb/tb_serial_add_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared constants for the serial adder controller: FSM encodings, the
// default operand width, and the state typedef used by the top.
package serial_add_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;

  // A new request is only looked at when no addition is in flight.
  function automatic logic can_start(input state_t s);
    return (s == IDLE) || (s == DONE);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// Single-bit full adder; the only arithmetic resource in the serial adder.
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared full adder walks the operands LSB first over
// WIDTH cycles, then publishes {carry,sum} with a one-cycle done pulse.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] res_next;

  FullAdder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_co)
  );

  // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  assign res_next = {fa_s, res_sh[WIDTH-1:1]};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_sum   <= '0;
      o_carry <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          o_done <= 1'b0;
          if (i_start && can_start(state)) begin
            a_sh   <= i_a;
            b_sh   <= i_b;
            carry  <= i_cin;
            res_sh <= '0;
            cnt    <= '0;
            o_busy <= 1'b1;
            state  <= SHIFT;
          end else begin
            state  <= IDLE;
          end
        end
        SHIFT: begin
          res_sh <= res_next;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fa_co;
          if (cnt == LAST) begin
            // Counter parks at WIDTH-1; it is cleared on the next start.
            o_sum   <= res_next;
            o_carry <= fa_co;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
          o_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8: latency, arithmetic corners,
// ignored starts, mid-op reset, back-to-back starts and a random sweep.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         i_clk = 1'b0;
  logic         i_reset = 1'b1;
  logic         i_start = 1'b0;
  logic [W-1:0] i_a = '0;
  logic [W-1:0] i_b = '0;
  logic         i_cin = 1'b0;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_sum;
  logic         o_carry;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (i_start),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_cin   (i_cin),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_sum   (o_sum),
    .o_carry (o_carry)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start in "cycle 0", then walk cycles 1..W+1 checking busy/done and that
  // the published result holds until the done cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [W-1:0] es, input logic ec);
    logic [W-1:0] held_s;
    logic         held_c;
    held_s = o_sum;
    held_c = o_carry;
    i_a = a; i_b = b; i_cin = cin; i_start = 1'b1;
    step();
    i_start = 1'b0;
    i_a = ~a; i_b = ~b; i_cin = ~cin;
    for (int k = 1; k <= W; k++) begin
      chk($sformatf("busy_c%0d", k), 32'(o_busy), 32'd1);
      chk($sformatf("nodone_c%0d", k), 32'(o_done), 32'd0);
      chk("hold_sum", 32'(o_sum), 32'(held_s));
      chk("hold_carry", 32'(o_carry), 32'(held_c));
      step();
    end
    chk("done_pulse", 32'(o_done), 32'd1);
    chk("busy_low_done", 32'(o_busy), 32'd0);
    chk("sum", 32'(o_sum), 32'(es));
    chk("carry", 32'(o_carry), 32'(ec));
    step();
    chk("done_one_cycle", 32'(o_done), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   ref_v;
    int           last_done;
    int           waited;
    bit           seen_done;

    // Reset state, including reset overriding a simultaneous start.
    i_start = 1'b1;
    step(); step();
    i_start = 1'b0;
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_sum", 32'(o_sum), 32'd0);
    chk("rst_carry", 32'(o_carry), 32'd0);
    i_reset = 1'b0;
    step();
    chk("idle_busy", 32'(o_busy), 32'd0);

    // 0x5A+0x3C, then carry-out corners.
    run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    run_op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0);

    // Start during SHIFT is ignored.
    i_a = 8'h10; i_b = 8'h20; i_cin = 1'b0; i_start = 1'b1;
    step();
    i_start = 1'b0;
    seen_done = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 4) begin i_a = 8'hAA; i_start = 1'b1; end
      else i_start = 1'b0;
      if (o_done) begin
        chk("ign_done_cycle", 32'(k), 32'(W + 1));
        chk("ign_sum", 32'(o_sum), 32'h30);
        chk("ign_carry", 32'(o_carry), 32'd0);
        seen_done = 1;
      end
      step();
    end
    i_start = 1'b0;
    chk("ign_seen_done", 32'(seen_done), 32'd1);
    step(); step();

    // Reset in cycle 5 aborts the operation.
    i_a = 8'h7F; i_b = 8'h01; i_cin = 1'b1; i_start = 1'b1;
    step();
    i_start = 1'b0;
    step(); step(); step(); step();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_sum", 32'(o_sum), 32'd0);
    chk("abort_carry", 32'(o_carry), 32'd0);
    seen_done = 0;
    for (int k = 0; k < 12; k++) begin
      if (o_done || o_busy) seen_done = 1;
      step();
    end
    chk("abort_quiet", 32'(seen_done), 32'd0);

    // First start after reset keeps normal latency.
    run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

    // Back-to-back: start accepted in the DONE cycle.
    i_a = 8'h01; i_b = 8'h01; i_cin = 1'b0; i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int k = 1; k < W + 1; k++) step();
    chk("b2b_done9", 32'(o_done), 32'd1);
    chk("b2b_sum1", 32'(o_sum), 32'h02);
    chk("b2b_carry1", 32'(o_carry), 32'd0);
    i_a = 8'h80; i_b = 8'h80; i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk("b2b_busy10", 32'(o_busy), 32'd1);
    chk("b2b_nodone10", 32'(o_done), 32'd0);
    for (int k = W + 2; k < 2 * W + 2; k++) step();
    chk("b2b_done18", 32'(o_done), 32'd1);
    chk("b2b_sum2", 32'(o_sum), 32'h00);
    chk("b2b_carry2", 32'(o_carry), 32'd1);
    step();

    // Random sweep; each next start is raised in the DONE cycle.
    last_done = -1;
    ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
    i_a = ra; i_b = rb; i_cin = rc; i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      waited = 0;
      while (!o_done && waited < 3 * W) begin
        i_a = 8'($urandom); i_b = 8'($urandom);
        step();
        waited++;
      end
      if (!o_done) begin
        chk("rnd_timeout", 32'(o_done), 32'd1);
        break;
      end
      ref_v = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      if (n % 50 == 0 || {o_carry, o_sum} !== ref_v)
        chk($sformatf("rnd_%0d", n), 32'({o_carry, o_sum}), 32'(ref_v));
      if (last_done >= 0 && (cyc - last_done) < W + 1)
        chk("rnd_spacing", 32'(cyc - last_done), 32'(W + 1));
      last_done = cyc;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      i_a = ra; i_b = rb; i_cin = rc; i_start = (n < 999);
      step();
      i_start = 1'b0;
    end
    chk("rnd_final_idle", 32'(o_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
